btn_event_queue: RTL
====================

BTN_EVENT_QUEUE -- requirements
Module: btn_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset; rst=0 sampled at a clk edge resets the block.
REQ-004 SHALL have port btnUpEdges_in  input  4  one-cycle release-edge pulses, bit i = button i.
REQ-005 SHALL have port btnDownEdges_in  input  4  one-cycle press-edge pulses, bit i = button i.
REQ-006 SHALL have port evt_valid  output  1  head event available.
REQ-007 SHALL have port evt_code  output  3  head event: bit2 = 1 press / 0 release, bits1:0 = button index.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts head when evt_valid && evt_ready.
REQ-009 SHALL have port evt_count  output  $clog2(DEPTH+1)  entries currently in FIFO.
REQ-010 SHALL have port overflow  output  1  sticky lost-event flag.
REQ-011 SHALL have port overflow_clr  input  1  clears overflow.

Function
REQ-012 SHALL hold an 8-bit pending register, one bit per (button, direction); a set input pulse ORs into the bit at the next edge.
REQ-013 SHALL, each cycle the FIFO can accept, select one pending bit by fixed priority: press 0,1,2,3, then release 0,1,2,3; it writes that code and clears the bit at the same edge.
REQ-014 SHALL treat the FIFO as able to accept when evt_count<DEPTH, or when full and a pop occurs in the same cycle.
REQ-015 SHALL keep a pending bit set when an input pulse re-asserts it in the same cycle it is selected; the new pulse is not lost.
REQ-016 SHALL set overflow when a pulse arrives for a bit that is already pending and not being cleared that cycle; the pending bit stays 1.
REQ-017 SHALL give overflow_clr lower priority than a same-cycle overflow set.
REQ-018 SHALL latch a pulse at edge N; with an empty FIFO and no other pending bits, the event is written at edge N+1 and evt_valid=1 from N+1.
REQ-019 SHALL hold evt_valid and evt_code stable until accepted; pop occurs on evt_valid && evt_ready.
REQ-020 SHALL leave the FIFO unchanged and ignore evt_ready when evt_valid=0.
REQ-021 SHALL preserve event order exactly as written; pointers wrap modulo DEPTH.
REQ-022 SHALL update evt_count by +1 on push only, -1 on pop only, and 0 on both or neither.

Reset
REQ-023 SHALL, on rst=0: clear pending, FIFO pointers and evt_count to 0, set evt_valid=0, evt_code=0 and overflow=0.
REQ-024 SHALL discard input pulses in a reset cycle, including any operation in progress.

Structure
REQ-025 SHALL take the event code field positions, the priority order and the default DEPTH from shared package btn_evt_pkg.
REQ-026 SHALL build storage as one sub-module, sync_fifo (parameters WIDTH=3, DEPTH), with push/pop/full/empty/count; pending and arbitration logic stay in the top module.

Verification
REQ-027 SHALL check: single btnDownEdges_in=4'b0100 at edge N -> evt_valid=1, evt_code=3'b110 at N+1; evt_ready=1 -> evt_valid=0 next cycle.
REQ-028 SHALL check: btnDownEdges_in=4'b1001 and btnUpEdges_in=4'b0010 in one cycle -> codes 100, 111, 001 in that order.
REQ-029 SHALL check: evt_ready=0, 8 distinct pulses -> evt_count=8; 9th new pulse stays pending; one pop -> it is written in the same cycle, evt_count stays 8.
REQ-030 SHALL check: with a full FIFO, press-0 pending, press-0 pulses again -> overflow=1; overflow_clr -> 0; simultaneous set and clear -> 1.
REQ-031 SHALL check: rst=0 with 5 queued and 3 pending -> next cycle evt_count=0, evt_valid=0, and no stale events after release.
REQ-032 SHALL check: random pulses and evt_ready over 10k cycles -> output sequence matches the reference queue model, with no loss while overflow=0.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// rtl/btn_evt_pkg.sv - shared event code layout, priority order and defaults for the button event queue
package btn_evt_pkg;

    localparam int DEFAULT_DEPTH = 8;

    // Event code: bit2 = press(1)/release(0), bits1:0 = button index.
    localparam int CODE_W       = 3;
    localparam int CODE_DIR_BIT = 2;
    localparam int CODE_IDX_MSB = 1;
    localparam int CODE_IDX_LSB = 0;

    // Pending bit layout doubles as the priority order: lowest set bit wins,
    // so presses 0..3 occupy bits 0..3 and releases 0..3 occupy bits 4..7.
    localparam logic [2:0] PRESS_BASE   = 3'd0;
    localparam logic [2:0] RELEASE_BASE = 3'd4;

    typedef struct packed {
        logic       hit;
        logic [2:0] bit_idx;
    } sel_t;

    function automatic sel_t pick_pending(input logic [7:0] pend);
        sel_t s;
        s.hit     = |pend;
        s.bit_idx = PRESS_BASE;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) s.bit_idx = 3'(i);
        end
        return s;
    endfunction

    function automatic logic [CODE_W-1:0] code_of_bit(input logic [2:0] b);
        logic [CODE_W-1:0] c;
        c                            = '0;
        c[CODE_DIR_BIT]              = (b < RELEASE_BASE);
        c[CODE_IDX_MSB:CODE_IDX_LSB] = b[1:0];
        return c;
    endfunction

endpackage

// File: rtl/btn_event_queue_if.sv
// rtl/btn_event_queue_if.sv - event output stream between the queue and its consumer
interface btn_event_queue_if;
    logic                           evt_valid;
    logic [btn_evt_pkg::CODE_W-1:0] evt_code;
    logic                           evt_ready;

    modport master (output evt_valid, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; push while full is accepted only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst && do_push) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/btn_event_queue.sv
// rtl/btn_event_queue.sv - collects button edge pulses into pending bits and queues them by fixed priority
module btn_event_queue
    import btn_evt_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  btnUpEdges_in,
    input  logic [3:0]                  btnDownEdges_in,
    btn_event_queue_if.master           evt,
    output logic [$clog2(DEPTH+1)-1:0]  evt_count,
    output logic                        overflow,
    input  logic                        overflow_clr
);
    logic [7:0]        pending;
    logic [7:0]        pulses;
    logic [7:0]        clr_mask;
    sel_t              sel;
    logic              pop;
    logic              push;
    logic              full;
    logic              empty;
    logic              ovf_set;
    logic [CODE_W-1:0] push_code;

    assign pulses    = {btnUpEdges_in, btnDownEdges_in};
    assign sel       = pick_pending(pending);
    assign pop       = evt.evt_valid && evt.evt_ready;
    assign push      = sel.hit && (!full || pop);
    assign push_code = code_of_bit(sel.bit_idx);
    assign evt.evt_valid = !empty;

    always_comb begin
        clr_mask = 8'b0;
        if (push) clr_mask = 8'b1 << sel.bit_idx;
    end

    // A pulse onto a bit that is being drained this cycle re-arms it and is not a loss.
    assign ovf_set = |(pulses & pending & ~clr_mask);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending  <= 8'b0;
            overflow <= 1'b0;
        end else begin
            pending  <= (pending & ~clr_mask) | pulses;
            overflow <= ovf_set | (overflow & ~overflow_clr);
        end
    end

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_code),
        .pop       (pop),
        .pop_data  (evt.evt_code),
        .full      (full),
        .empty     (empty),
        .count     (evt_count)
    );
endmodule
